// File: rtl/wb_master_bridge.sv
`default_nettype none
// ============================================================================
// wb_master_bridge : valid/ready request -> classic single Wishbone cycle, with wait timeout
// Revision: 1.0
// ============================================================================
module wb_master_bridge #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int SEL_WIDTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADR_WIDTH-1:0] req_addr,
  input  logic [DAT_WIDTH-1:0] req_wdata,
  input  logic                 req_we,
  input  logic [SEL_WIDTH-1:0] req_sel,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DAT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [ADR_WIDTH-1:0] wb_adr,
  output logic [DAT_WIDTH-1:0] wb_datwr,
  input  logic [DAT_WIDTH-1:0] wb_datrd,
  output logic                 wb_we,
  output logic [SEL_WIDTH-1:0] wb_sel,
  output logic                 wb_stb,
  output logic                 wb_cyc,
  input  logic                 wb_ack
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic TIMEOUT_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADR_WIDTH-1:0]   adr_q, adr_d;
  logic [DAT_WIDTH-1:0]   datwr_q, datwr_d;
  logic                   we_q, we_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [DAT_WIDTH-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   w_expired;

  // Abort fires on the last allowed wait cycle; an ack in that same cycle wins.
  assign w_expired = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      datwr_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      datwr_q <= datwr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    datwr_d = datwr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          adr_d   = req_addr;
          datwr_d = req_wdata;
          we_d    = req_we;
          sel_d   = req_sel;
          cnt_d   = '0;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wb_ack) begin
          rdata_d = we_q ? '0 : wb_datrd;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (w_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign wb_cyc     = (state_q == ST_BUS);
  assign wb_stb     = (state_q == ST_BUS);
  assign wb_adr     = adr_q;
  assign wb_datwr   = datwr_q;
  assign wb_we      = we_q;
  assign wb_sel     = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_bridge.sv
`default_nettype none
// ============================================================================
// tb_wb_master_bridge : directed vectors with a response scoreboard
// Revision: 1.0
// ============================================================================
module tb_wb_master_bridge;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [3:0]  req_sel;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] wb_adr;
  logic [31:0] wb_datwr;
  logic [31:0] wb_datrd;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_ack;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_fail = 0;

  wb_master_bridge #(
    .ADR_WIDTH(32),
    .DAT_WIDTH(32),
    .SEL_WIDTH(4),
    .TIMEOUT  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_we    (req_we),
    .req_sel   (req_sel),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .wb_adr    (wb_adr),
    .wb_datwr  (wb_datwr),
    .wb_datrd  (wb_datrd),
    .wb_we     (wb_we),
    .wb_sel    (wb_sel),
    .wb_stb    (wb_stb),
    .wb_cyc    (wb_cyc),
    .wb_ack    (wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks run there or on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Responses are checked on the handshake cycle against the queued expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {63'd0, resp_valid}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_rdata", {32'd0, resp_rdata}, {32'd0, mon_e.rdata});
        chk("resp_err", {63'd0, resp_err}, {63'd0, mon_e.err});
      end
    end
  end

  // ack_wait < 0 means the slave never acknowledges.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                        input logic [3:0] sel, input int ack_wait, input logic [31:0] datrd,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_cycles, input int bp);
    int   cycles;
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    resp_ready = (bp == 0);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_wdata  = wdata;
    req_we     = we;
    req_sel    = sel;
    tick();
    req_valid  = 1'b0;
    req_addr   = ~addr;
    req_wdata  = ~wdata;
    req_we     = ~we;
    req_sel    = ~sel;
    cycles     = 0;
    while (wb_cyc && cycles < 40) begin
      chk("wb_adr", {32'd0, wb_adr}, {32'd0, addr});
      chk("wb_datwr", {32'd0, wb_datwr}, {32'd0, wdata});
      chk("wb_we", {63'd0, wb_we}, {63'd0, we});
      chk("wb_sel", {60'd0, wb_sel}, {60'd0, sel});
      chk("wb_stb", {63'd0, wb_stb}, 64'd1);
      wb_ack   = (cycles == ack_wait);
      wb_datrd = datrd;
      tick();
      cycles++;
    end
    wb_ack = 1'b0;
    chk("bus_cycles", 64'(cycles), 64'(exp_cycles));
    chk("resp_valid", {63'd0, resp_valid}, 64'd1);
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'h0000_0999;
      tick();
      chk("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("bp_rdata", {32'd0, resp_rdata}, {32'd0, exp_rdata});
      chk("bp_err", {63'd0, resp_err}, {63'd0, exp_err});
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
      chk("bp_wb_cyc", {63'd0, wb_cyc}, 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    chk("req_ready_after", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_we     = 1'b0;
    req_sel    = 4'h0;
    resp_ready = 1'b1;
    wb_ack     = 1'b0;
    wb_datrd   = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    chk("rst_wb_cyc", {63'd0, wb_cyc}, 64'd0);
    chk("rst_wb_stb", {63'd0, wb_stb}, 64'd0);
    chk("rst_wb_we", {63'd0, wb_we}, 64'd0);
    chk("rst_wb_adr", {32'd0, wb_adr}, 64'd0);
    chk("rst_wb_datwr", {32'd0, wb_datwr}, 64'd0);
    chk("rst_wb_sel", {60'd0, wb_sel}, 64'd0);

    // Stray ack while idle must not move the FSM.
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    chk("stray_ack_ready", {63'd0, req_ready}, 64'd1);
    chk("stray_ack_resp", {63'd0, resp_valid}, 64'd0);
    chk("stray_ack_cyc", {63'd0, wb_cyc}, 64'd0);
    tick();

    do_txn(32'h0000_0100, 32'h0, 1'b0, 4'hF, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1, 0);
    do_txn(32'h0000_0200, 32'h1234_5678, 1'b1, 4'h3, 3, 32'hFFFF_FFFF, 32'h0, 1'b0, 4, 0);
    do_txn(32'h0000_0300, 32'h0, 1'b0, 4'hF, -1, 32'hBADC_0DE5, 32'h0, 1'b1, 16, 0);
    do_txn(32'h0000_0400, 32'h0, 1'b0, 4'hC, 15, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 16, 0);
    do_txn(32'h0000_0500, 32'h0, 1'b0, 4'hF, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 2, 5);

    // Reset at wait cycle 2 abandons the transfer with no response.
    req_valid = 1'b1;
    req_addr  = 32'h0000_0600;
    req_wdata = 32'hAAAA_5555;
    req_we    = 1'b1;
    req_sel   = 4'hF;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("mid_rst_cyc_before", {63'd0, wb_cyc}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cyc", {63'd0, wb_cyc}, 64'd0);
    chk("mid_rst_stb", {63'd0, wb_stb}, 64'd0);
    chk("mid_rst_resp", {63'd0, resp_valid}, 64'd0);
    chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
    chk("mid_rst_adr", {32'd0, wb_adr}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_no_resp", {63'd0, resp_valid}, 64'd0);
    end

    do_txn(32'h0000_0700, 32'h5A5A_A5A5, 1'b1, 4'h1, 0, 32'h1111_2222, 32'h0, 1'b0, 1, 0);

    repeat (3) tick();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 The block SHALL have parameter ADR_WIDTH, default 32, the Wishbone and request address width.
REQ-002 The block SHALL have parameter DAT_WIDTH, default 32, the Wishbone and request data width.
REQ-003 The block SHALL have parameter SEL_WIDTH, default 4, the byte-select width (DAT_WIDTH/8).
REQ-004 The block SHALL have parameter TIMEOUT, default 16, the number of bus-wait cycles before abort; 0 disables the timeout.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high (ports clk and rst).
REQ-006 The ports SHALL be:
  clk         in   1          clock, all logic on rising edge
  rst         in   1          synchronous active-high reset
  req_valid   in   1          upstream request valid
  req_ready   out  1          bridge can accept a request
  req_addr    in   ADR_WIDTH  request address
  req_wdata   in   DAT_WIDTH  write data
  req_we      in   1          1 = write, 0 = read
  req_sel     in   SEL_WIDTH  byte enables
  resp_valid  out  1          response valid
  resp_ready  in   1          upstream accepts response
  resp_rdata  out  DAT_WIDTH  read data (0 for writes and errors)
  resp_err    out  1          1 = transfer aborted by timeout
  wb_adr      out  ADR_WIDTH  Wishbone master adr
  wb_datwr    out  DAT_WIDTH  Wishbone master datwr
  wb_datrd    in   DAT_WIDTH  Wishbone master datrd
  wb_we       out  1          Wishbone we
  wb_sel      out  SEL_WIDTH  Wishbone sel
  wb_stb      out  1          Wishbone stb
  wb_cyc      out  1          Wishbone cyc
  wb_ack      in   1          Wishbone ack

Function
REQ-007 The FSM SHALL have three states: IDLE, BUS, RESP; all outputs SHALL be registered or decoded from state only.
REQ-008 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid && req_ready.
REQ-009 On acceptance, req_addr/wdata/we/sel SHALL be latched into wb_adr/wb_datwr/wb_we/wb_sel and the FSM SHALL enter BUS on the next edge.
REQ-010 In BUS, wb_cyc and wb_stb SHALL both be 1 and wb_adr/datwr/we/sel SHALL be held stable; outside BUS, wb_cyc = wb_stb = 0.
REQ-011 In BUS with wb_ack = 1: resp_rdata SHALL capture wb_datrd for reads (0 for writes), resp_err SHALL be 0, FSM -> RESP; wb_cyc/wb_stb drop on the following cycle (classic single cycle, no pipelining).
REQ-012 Wait counter SHALL clear on entering BUS and increment each BUS cycle without ack; when TIMEOUT != 0 and counter == TIMEOUT-1 with no ack, FSM -> RESP with resp_err = 1, resp_rdata = 0.
REQ-013 Ack on the timeout cycle SHALL take priority (normal completion, resp_err = 0).
REQ-014 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err stable until resp_ready; on resp_valid && resp_ready FSM -> IDLE.
REQ-015 wb_ack outside BUS SHALL be ignored with no state change.
REQ-016 Minimum latency: accept at cycle N, stb at N+1, ack at N+1 -> resp_valid at N+2; next req_ready at N+3 if resp_ready at N+2.
REQ-017 Counter width SHALL be $clog2(TIMEOUT+1), minimum 1 bit; no wrap-around possible before abort.

Reset
REQ-018 On rst = 1 at a clock edge: FSM -> IDLE, req_ready = 1 after reset, resp_valid = 0, resp_err = 0, resp_rdata = 0, wb_cyc = wb_stb = 0, wb_we = 0, wb_adr/datwr/sel = 0, counter = 0.
REQ-019 Reset mid-transfer (BUS or RESP) SHALL abandon the transfer; wb_cyc/wb_stb SHALL be 0 in the cycle after the reset edge and no response SHALL be issued.

Verification
REQ-020 Read: req addr 0x100, we=0, sel 0xF; slave acks 1 cycle later with datrd 0xDEADBEEF -> resp_valid, rdata 0xDEADBEEF, err 0.
REQ-021 Write: addr 0x200, wdata 0x12345678, sel 0x3; slave acks after 3 wait cycles -> wb_* stable all 4 BUS cycles, resp rdata 0, err 0.
REQ-022 Timeout: TIMEOUT=16, slave never acks -> cyc high exactly 16 cycles, then resp_err 1, rdata 0.
REQ-023 Backpressure: resp_ready held 0 for 5 cycles -> resp_valid/rdata held, req_ready 0, no new wb_cyc.
REQ-024 Reset during BUS at wait cycle 2 -> wb_cyc 0 next cycle, resp_valid never asserted, req_ready 1.
REQ-025 Ack on timeout cycle (ack at wait count 15, TIMEOUT=16) -> err 0, rdata = wb_datrd.
